// File: rtl/param_delay_line_if.sv
// Bundles the data/control bus of param_delay_line.
// The master drives the samples and controls; the slave returns the tap and occupancy.
interface param_delay_line_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
);
    localparam int SEL_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             en;
    logic             flush;
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic [SEL_W-1:0] dly_sel;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [CNT_W-1:0] fill_cnt;

    modport master (
        output en, flush, in, in_valid, dly_sel,
        input  out, out_valid, fill_cnt
    );

    modport slave (
        input  en, flush, in, in_valid, dly_sel,
        output out, out_valid, fill_cnt
    );
endinterface

// File: rtl/param_delay_line.sv
// Stallable WIDTH x DEPTH register delay line with per-stage valid bits,
// a runtime tap select and a registered occupancy count.
module param_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    param_delay_line_if.slave    bus
);
    localparam int SEL_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_d [DEPTH];
    logic             r_v [DEPTH];
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] w_tap;

    // Selects above the last stage alias onto it (only reachable for non-power-of-two DEPTH).
    function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] sel);
        if (int'(sel) > DEPTH - 1) begin
            return SEL_W'(DEPTH - 1);
        end
        return sel;
    endfunction

    always_ff @(posedge sys_clk) begin
        if (sys_rst || bus.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= '0;
                r_v[k] <= 1'b0;
            end
            r_cnt <= '0;
        end else if (bus.en) begin
            r_d[0] <= bus.in;
            r_v[0] <= bus.in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                r_d[k] <= r_d[k-1];
                r_v[k] <= r_v[k-1];
            end
            // Entry in, oldest entry out: tracks popcount of r_v without a full adder tree.
            r_cnt <= r_cnt + CNT_W'(bus.in_valid) - CNT_W'(r_v[DEPTH-1]);
        end
    end

    always_comb begin
        w_tap = clamp_sel(bus.dly_sel);
    end

    assign bus.out       = r_d[w_tap];
    assign bus.out_valid = r_v[w_tap];
    assign bus.fill_cnt  = r_cnt;
endmodule

// File: tb/tb_param_delay_line.sv
// Directed bench for param_delay_line (DEPTH=4 and DEPTH=6 instances) plus a
// short randomised run of the DEPTH=6 instance against a queue model.
module tb_param_delay_line;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [1:0] q_d [$];
    logic       q_v [$];

    always #5 clk = ~clk;

    param_delay_line_if #(.WIDTH(2), .DEPTH(4)) b4 ();
    param_delay_line_if #(.WIDTH(2), .DEPTH(6)) b6 ();

    param_delay_line #(.WIDTH(2), .DEPTH(4)) dut4 (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (b4.slave)
    );

    param_delay_line #(.WIDTH(2), .DEPTH(6)) dut6 (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (b6.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [1:0] o, input logic ov, input logic [2:0] fc);
        chk({tag, ".out"}, 32'(b4.out), 32'(o));
        chk({tag, ".out_valid"}, 32'(b4.out_valid), 32'(ov));
        chk({tag, ".fill_cnt"}, 32'(b4.fill_cnt), 32'(fc));
    endtask

    // Push one valid sample at the given select, then bubbles; it must surface only at edge 6.
    task automatic probe6(input string tag, input logic [2:0] sel, input logic [1:0] val);
        b6.dly_sel  = sel;
        b6.en       = 1'b1;
        b6.in       = val;
        b6.in_valid = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            b6.in       = 2'd0;
            b6.in_valid = 1'b0;
            chk($sformatf("%s.e%0d.out_valid", tag, e), 32'(b6.out_valid), (e == 6) ? 32'd1 : 32'd0);
            if (e == 6) chk($sformatf("%s.e6.out", tag), 32'(b6.out), 32'(val));
        end
    endtask

    initial begin
        int          t;
        int          cnt;
        logic [1:0]  exp_d;
        logic        exp_v;

        // 1. Reset with live-looking inputs
        rst = 1'b1;
        b4.en = 1'b1; b4.flush = 1'b0; b4.in = 2'd3; b4.in_valid = 1'b1; b4.dly_sel = 2'd0;
        b6.en = 1'b0; b6.flush = 1'b0; b6.in = 2'd0; b6.in_valid = 1'b0; b6.dly_sel = 3'd0;
        step(); chk4("rst1", 2'd0, 1'b0, 3'd0);
        step(); chk4("rst2", 2'd0, 1'b0, 3'd0);
        rst = 1'b0; b4.en = 1'b0;
        step(); chk4("rst_rel", 2'd0, 1'b0, 3'd0);

        // 2. Minimum latency
        b4.en = 1'b1; b4.in_valid = 1'b1; b4.dly_sel = 2'd0;
        b4.in = 2'd1; step(); chk4("lat0_a", 2'd1, 1'b1, 3'd1);
        b4.in = 2'd2; step(); chk4("lat0_b", 2'd2, 1'b1, 3'd2);
        b4.in = 2'd3; step(); chk4("lat0_c", 2'd3, 1'b1, 3'd3);
        b4.in = 2'd0; step(); chk4("lat0_d", 2'd0, 1'b1, 3'd4);
        b4.in = 2'd1; step(); chk4("lat0_full", 2'd1, 1'b1, 3'd4);

        // 3. Maximum tap
        b4.flush = 1'b1; step(); chk4("flush3", 2'd0, 1'b0, 3'd0);
        b4.flush = 1'b0; b4.dly_sel = 2'd3;
        b4.in = 2'd2; b4.in_valid = 1'b1; step(); chk4("tap3_e1", 2'd0, 1'b0, 3'd1);
        b4.in = 2'd0; b4.in_valid = 1'b0;
        step(); chk4("tap3_e2", 2'd0, 1'b0, 3'd1);
        step(); chk4("tap3_e3", 2'd0, 1'b0, 3'd1);
        step(); chk4("tap3_e4", 2'd2, 1'b1, 3'd1);
        step(); chk4("tap3_e5", 2'd0, 1'b0, 3'd0);

        // 4. Stall
        b4.dly_sel = 2'd1; b4.in_valid = 1'b1;
        b4.in = 2'd1; step(); chk4("stall_s1", 2'd0, 1'b0, 3'd1);
        b4.in = 2'd2; step(); chk4("stall_s2", 2'd1, 1'b1, 3'd2);
        b4.in = 2'd3; step(); chk4("stall_s3", 2'd2, 1'b1, 3'd3);
        b4.en = 1'b0; b4.in = 2'd0;
        for (int i = 0; i < 3; i++) begin
            step(); chk4($sformatf("stall_hold%0d", i), 2'd2, 1'b1, 3'd3);
        end
        b4.en = 1'b1; b4.in_valid = 1'b0;
        step(); chk4("stall_resume1", 2'd3, 1'b1, 3'd3);
        step(); chk4("stall_resume2", 2'd0, 1'b0, 3'd2);

        // 5. Flush colliding with a valid input on a full line
        b4.flush = 1'b1; b4.en = 1'b0; step();
        b4.flush = 1'b0; b4.en = 1'b1; b4.in_valid = 1'b1; b4.in = 2'd1; b4.dly_sel = 2'd0;
        for (int i = 0; i < 4; i++) step();
        chk("fl_full.fill_cnt", 32'(b4.fill_cnt), 32'd4);
        b4.flush = 1'b1; b4.in = 2'd3;
        step();
        chk("fl_col.fill_cnt", 32'(b4.fill_cnt), 32'd0);
        for (int s = 0; s < 4; s++) begin
            b4.dly_sel = 2'(s); #1;
            chk($sformatf("fl_col.tap%0d.out_valid", s), 32'(b4.out_valid), 32'd0);
        end
        b4.flush = 1'b0; b4.in = 2'd0; b4.in_valid = 1'b0; b4.dly_sel = 2'd3;
        for (int i = 0; i < 4; i++) begin
            step(); chk4($sformatf("fl_after%0d", i), 2'd0, 1'b0, 3'd0);
        end
        b4.en = 1'b0;

        // 6. Clamp on DEPTH=6, then random run against a queue model
        probe6("clamp7", 3'd7, 2'd3);
        probe6("sel5", 3'd5, 2'd2);
        b6.flush = 1'b1; step(); b6.flush = 1'b0;
        q_d.delete(); q_v.delete();
        for (int c = 0; c < 200; c++) begin
            b6.en       = ($urandom_range(0, 3) != 0);
            b6.flush    = ($urandom_range(0, 15) == 0);
            b6.in       = 2'($urandom_range(0, 3));
            b6.in_valid = 1'($urandom_range(0, 1));
            b6.dly_sel  = 3'($urandom_range(0, 7));
            step();
            if (b6.flush) begin
                q_d.delete(); q_v.delete();
            end else if (b6.en) begin
                q_d.push_front(b6.in); q_v.push_front(b6.in_valid);
                if (q_d.size() > 6) begin
                    void'(q_d.pop_back()); void'(q_v.pop_back());
                end
            end
            t = (int'(b6.dly_sel) > 5) ? 5 : int'(b6.dly_sel);
            exp_d = (t < q_d.size()) ? q_d[t] : 2'd0;
            exp_v = (t < q_v.size()) ? q_v[t] : 1'b0;
            cnt = 0;
            foreach (q_v[i]) cnt += int'(q_v[i]);
            chk($sformatf("rnd%0d.out", c), 32'(b6.out), 32'(exp_d));
            chk($sformatf("rnd%0d.out_valid", c), 32'(b6.out_valid), 32'(exp_v));
            chk($sformatf("rnd%0d.fill_cnt", c), 32'(b6.fill_cnt), 32'(cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
